ones_window_counter: RTL and testbench

ONES_WINDOW_COUNTER -- requirements
Module: ones_window_counter

---
 rtl/ones_window_counter.sv | 141 ++++++++++++++
 tb/tb_ones_window_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ones_window_counter.sv
// Counts ones among accepted serial samples in fixed-length windows and hands
// each completed window count to a single-entry valid/ready result slot.
module ones_window_counter #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned WIN_LEN  = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    input  logic             data_vld,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic [CNT_W-1:0] res_data,
    output logic             res_sat,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic             res_ovf
);

    localparam int unsigned      POS_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIN_LEN - 1);

    typedef enum logic {StEmpty, StFull} slot_state_e;

    slot_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] res_data_q, res_data_d;
    logic             res_sat_q, res_sat_d;
    logic             res_ovf_q, res_ovf_d;

    logic             accept;
    logic             complete;
    logic [CNT_W-1:0] cnt_upd;
    logic             sat_upd;

    assign accept   = data_vld & ~clr;
    assign complete = accept & (pos_q == POS_LAST);

    // Window totals including the current sample; sat marks reaching or passing max.
    always_comb begin
        cnt_upd = count_q;
        sat_upd = sat_q;
        if (data) begin
            if (count_q == CNT_MAX) begin
                cnt_upd = SATURATE ? CNT_MAX : '0;
                sat_upd = 1'b1;
            end else begin
                cnt_upd = count_q + CNT_W'(1);
                if (count_q == CNT_MAX - CNT_W'(1)) begin
                    sat_upd = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        pos_d   = pos_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
            pos_d   = '0;
        end else if (accept) begin
            if (complete) begin
                count_d = '0;
                sat_d   = 1'b0;
                pos_d   = '0;
            end else begin
                count_d = cnt_upd;
                sat_d   = sat_upd;
                pos_d   = pos_q + POS_W'(1);
            end
        end
    end

    // Result slot: a completion replaces the held result only if it is leaving this cycle.
    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_sat_d  = res_sat_q;
        res_ovf_d  = res_ovf_q;
        unique case (state_q)
            StEmpty: begin
                if (complete) begin
                    res_data_d = cnt_upd;
                    res_sat_d  = sat_upd;
                    state_d    = StFull;
                end
            end
            StFull: begin
                if (complete) begin
                    if (res_rdy) begin
                        res_data_d = cnt_upd;
                        res_sat_d  = sat_upd;
                    end else begin
                        res_ovf_d = 1'b1;
                    end
                end else if (res_rdy) begin
                    state_d = StEmpty;
                end
            end
        endcase
        if (clr) begin
            res_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StEmpty;
            count_q    <= '0;
            sat_q      <= 1'b0;
            pos_q      <= '0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            pos_q      <= pos_d;
            res_data_q <= res_data_d;
            res_sat_q  <= res_sat_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign count    = count_q;
    assign sat      = sat_q;
    assign res_data = res_data_q;
    assign res_sat  = res_sat_q;
    assign res_vld  = (state_q == StFull);
    assign res_ovf  = res_ovf_q;

endmodule

// File: tb/tb_ones_window_counter.sv
// Directed bench: stimulus pushes expected window results, a negedge monitor
// pops them whenever a new result is presented on the slot.
module tb_ones_window_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       data;
    logic       data_vld;
    logic       clr;
    logic       res_rdy;
    logic [3:0] count;
    logic       sat;
    logic [3:0] res_data;
    logic       res_sat;
    logic       res_vld;
    logic       res_ovf;

    logic [3:0] w_count;
    logic       w_sat;
    logic [3:0] w_res_data;
    logic       w_res_sat;
    logic       w_res_vld;
    logic       w_res_ovf;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];  // {sat, data}

    always #5 clk = ~clk;

    ones_window_counter #(.CNT_W(4), .WIN_LEN(16), .SATURATE(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .data_vld (data_vld),
        .clr      (clr),
        .count    (count),
        .sat      (sat),
        .res_data (res_data),
        .res_sat  (res_sat),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .res_ovf  (res_ovf)
    );

    // Wrapping variant sharing all stimulus.
    ones_window_counter #(.CNT_W(4), .WIN_LEN(16), .SATURATE(1'b0)) dut_w (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .data_vld (data_vld),
        .clr      (clr),
        .count    (w_count),
        .sat      (w_sat),
        .res_data (w_res_data),
        .res_sat  (w_res_sat),
        .res_vld  (w_res_vld),
        .res_rdy  (res_rdy),
        .res_ovf  (w_res_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic d);
        data     = d;
        data_vld = 1'b1;
        step();
        data_vld = 1'b0;
        data     = 1'b0;
    endtask

    task automatic run_samples(input int n, input logic [31:0] pattern);
        for (int i = 0; i < n; i++) begin
            sample(pattern[i]);
        end
    endtask

    // A new result is on the slot when res_vld rises or stays high after a transfer.
    logic vld_prev  = 1'b0;
    logic xfer_prev = 1'b0;
    always @(negedge clk) begin
        logic [4:0] e;
        if (res_vld === 1'b1 && (!vld_prev || xfer_prev)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0d sat %0b, none expected",
                         res_data, res_sat);
            end else begin
                e = exp_q.pop_front();
                chk("mon_res_data", 32'(res_data), 32'(e[3:0]));
                chk("mon_res_sat", 32'(res_sat), 32'(e[4]));
            end
        end
        vld_prev  = (res_vld === 1'b1);
        xfer_prev = vld_prev && (res_rdy === 1'b1);
    end

    initial begin
        // Reset with random inputs
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data     = 1'($urandom);
            data_vld = 1'($urandom);
            clr      = 1'($urandom);
            res_rdy  = 1'($urandom);
            step();
        end
        chk("rst_count", 32'(count), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_sat", 32'(res_sat), 0);
        chk("rst_res_vld", 32'(res_vld), 0);
        chk("rst_res_ovf", 32'(res_ovf), 0);
        data = 1'b0; data_vld = 1'b0; clr = 1'b0; res_rdy = 1'b0;
        reset = 1'b1;

        // Alternating 1010... window: 8 ones
        run_samples(8, 32'h5555);
        chk("alt_mid_count", 32'(count), 4);
        run_samples(7, 32'h0055);
        exp_q.push_back({1'b0, 4'd8});
        sample(1'b0);
        chk("alt_res_vld", 32'(res_vld), 1);
        chk("alt_count_cleared", 32'(count), 0);
        res_rdy = 1'b1; step(); res_rdy = 1'b0;
        chk("alt_drained", 32'(res_vld), 0);

        // All ones: saturate on the main instance, wrap on dut_w
        run_samples(14, 32'hffff);
        chk("ones14_count", 32'(count), 14);
        chk("ones14_sat", 32'(sat), 0);
        sample(1'b1);
        chk("ones15_count", 32'(count), 15);
        chk("ones15_sat", 32'(sat), 1);
        exp_q.push_back({1'b1, 4'd15});
        sample(1'b1);
        chk("ones_sat_after", 32'(sat), 0);
        chk("wrap_res_data", 32'(w_res_data), 0);
        chk("wrap_res_sat", 32'(w_res_sat), 1);
        res_rdy = 1'b1; step(); res_rdy = 1'b0;

        // Two windows without acceptance: second is dropped
        exp_q.push_back({1'b0, 4'd3});
        run_samples(16, 32'h0007);
        chk("ovf_first_clear", 32'(res_ovf), 0);
        run_samples(16, 32'hffff);
        chk("ovf_set", 32'(res_ovf), 1);
        chk("ovf_res_data_held", 32'(res_data), 3);
        chk("ovf_res_sat_held", 32'(res_sat), 0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_ovf", 32'(res_ovf), 0);
        chk("clr_keeps_vld", 32'(res_vld), 1);

        // Completion with slot full and res_rdy high replaces the result
        run_samples(15, 32'h001f);
        exp_q.push_back({1'b0, 4'd5});
        res_rdy = 1'b1;
        sample(1'b0);
        res_rdy = 1'b0;
        chk("replace_vld", 32'(res_vld), 1);
        chk("replace_ovf", 32'(res_ovf), 0);
        chk("replace_data", 32'(res_data), 5);
        res_rdy = 1'b1; step(); res_rdy = 1'b0;
        chk("replace_drained", 32'(res_vld), 0);

        // Gaps between samples, then clr overriding a valid sample
        for (int i = 0; i < 5; i++) begin
            sample(1'b1);
            repeat (3) step();
        end
        chk("gap_count", 32'(count), 5);
        clr = 1'b1; data = 1'b1; data_vld = 1'b1;
        step();
        clr = 1'b0; data = 1'b0; data_vld = 1'b0;
        chk("clr_count", 32'(count), 0);
        run_samples(15, 32'hffff);
        chk("clr_no_early_result", 32'(res_vld), 0);
        chk("clr_window_count", 32'(count), 15);
        exp_q.push_back({1'b1, 4'd15});
        sample(1'b0);
        chk("clr_window_done", 32'(res_vld), 1);
        res_rdy = 1'b1; step(); res_rdy = 1'b0;

        // Reset with a pending result and a partial window
        run_samples(15, 32'h0000);
        exp_q.push_back({1'b0, 4'd0});
        sample(1'b0);
        run_samples(7, 32'hffff);
        chk("pre_rst_count", 32'(count), 7);
        chk("pre_rst_vld", 32'(res_vld), 1);
        reset = 1'b0; data = 1'b1; data_vld = 1'b1; res_rdy = 1'b1;
        step();
        reset = 1'b1; data = 1'b0; data_vld = 1'b0; res_rdy = 1'b0;
        chk("rst_mid_vld", 32'(res_vld), 0);
        chk("rst_mid_count", 32'(count), 0);
        run_samples(15, 32'h01ff);
        chk("post_rst_no_early", 32'(res_vld), 0);
        exp_q.push_back({1'b0, 4'd9});
        sample(1'b0);
        chk("post_rst_vld", 32'(res_vld), 1);
        chk("post_rst_count", 32'(count), 0);
        res_rdy = 1'b1; step(); res_rdy = 1'b0;
        chk("final_drained", 32'(res_vld), 0);

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
